// File: rtl/stopwatch_pkg.sv
// Shared state encoding, BCD digit limits and default clocking for the stopwatch.
// Latency: none (declarations only).
// Backpressure: none.
//
// Contents: state_t (IDLE/UP/DOWN/PAUSED), per-digit maximum values, default
// clock and step rates, and a range check used to accept or reject presets.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_UP     = 2'd1,
        ST_DOWN   = 2'd2,
        ST_PAUSED = 2'd3
    } state_t;

    localparam int MAX_MINUTE    = 9;
    localparam int MAX_SEC_TENS  = 5;
    localparam int MAX_SEC_UNITS = 9;
    localparam int MAX_TENTH     = 9;

    localparam int DEF_CLK_HZ  = 100_000_000;
    localparam int DEF_TICK_HZ = 10;

    // True when every preset digit is a legal value for its position.
    function automatic logic digits_in_range(
        input logic [3:0] minute,
        input logic [3:0] sec_tens,
        input logic [3:0] sec_units,
        input logic [3:0] tenth
    );
        return (minute    <= 4'(MAX_MINUTE))    &&
               (sec_tens  <= 4'(MAX_SEC_TENS))  &&
               (sec_units <= 4'(MAX_SEC_UNITS)) &&
               (tenth     <= 4'(MAX_TENTH));
    endfunction

endpackage

// File: rtl/stopwatch_digit.sv
// One BCD digit that counts 0..MAX with wrap-around, chainable through carry/borrow.
// Latency: value updates on the clock edge after inc/dec/load; carry/borrow are combinational.
// Backpressure: none; load wins over inc, inc wins over dec.
//
// Ports: i_clock, i_reset (sync, active-high), i_inc, i_dec, i_load, i_load_val[3:0]
//        -> o_value[3:0], o_carry (wrapping MAX->0), o_borrow (wrapping 0->MAX).
module stopwatch_digit
    import stopwatch_pkg::*;
#(
    parameter int MAX = 9
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       i_inc,
    input  logic       i_dec,
    input  logic       i_load,
    input  logic [3:0] i_load_val,
    output logic [3:0] o_value,
    output logic       o_carry,
    output logic       o_borrow
);

    localparam logic [3:0] MAX_VAL = 4'(MAX);

    logic [3:0] r_value;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_value <= '0;
        end else if (i_load) begin
            r_value <= i_load_val;
        end else if (i_inc) begin
            r_value <= (r_value == MAX_VAL) ? 4'd0 : r_value + 4'd1;
        end else if (i_dec) begin
            r_value <= (r_value == 4'd0) ? MAX_VAL : r_value - 4'd1;
        end
    end

    assign o_value  = r_value;
    assign o_carry  = i_inc && (r_value == MAX_VAL);
    assign o_borrow = i_dec && (r_value == 4'd0);

endmodule

// File: rtl/stopwatch_bcd_counter.sv
// Stopwatch M:ST:SU.T in BCD, stepping one tenth every TICK_DIV cycles, up or down.
// Latency: commands act on the next edge; done/load_err are registered one-cycle pulses.
// Backpressure: none; one-cycle command pulses, priority clear > load > start > pause.
//
// Ports: i_clock, i_reset (sync, active-high); command pulses i_start_up, i_start_down,
//        i_pause, i_clear, i_load with preset digits i_load_*; outputs o_minute,
//        o_sec_tens, o_sec_units, o_tenth, o_count_up_enable, o_count_down_enable,
//        o_done, o_load_err.
module stopwatch_bcd_counter
    import stopwatch_pkg::*;
#(
    parameter int CLK_HZ   = DEF_CLK_HZ,
    parameter int TICK_HZ  = DEF_TICK_HZ,
    parameter int TICK_DIV = CLK_HZ / TICK_HZ
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       i_start_up,
    input  logic       i_start_down,
    input  logic       i_pause,
    input  logic       i_clear,
    input  logic       i_load,
    input  logic [3:0] i_load_minute,
    input  logic [3:0] i_load_sec_tens,
    input  logic [3:0] i_load_sec_units,
    input  logic [3:0] i_load_tenth,
    output logic [3:0] o_minute,
    output logic [3:0] o_sec_tens,
    output logic [3:0] o_sec_units,
    output logic [3:0] o_tenth,
    output logic       o_count_up_enable,
    output logic       o_count_down_enable,
    output logic       o_done,
    output logic       o_load_err
);

    localparam int              DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    state_t           r_state, w_state_nxt;
    logic [DIV_W-1:0] r_div, w_div_nxt;
    logic             r_done, w_done_nxt;
    logic             r_load_err, w_err_nxt;

    logic       w_step_up, w_step_dn, w_dig_load, w_run_step, w_running;
    logic [3:0] w_ld_min, w_ld_st, w_ld_su, w_ld_te;
    logic [3:0] w_min, w_st, w_su, w_te;
    logic       w_te_cy, w_su_cy, w_st_cy, w_unused_min_cy;
    logic       w_te_bw, w_su_bw, w_st_bw, w_unused_min_bw;
    logic       w_at_max, w_at_zero, w_pre_max, w_pre_zero;

    assign w_running  = (r_state == ST_UP) || (r_state == ST_DOWN);
    assign w_at_max   = (w_min == 4'(MAX_MINUTE)) && (w_st == 4'(MAX_SEC_TENS)) &&
                        (w_su == 4'(MAX_SEC_UNITS)) && (w_te == 4'(MAX_TENTH));
    assign w_at_zero  = (w_min == 4'd0) && (w_st == 4'd0) && (w_su == 4'd0) && (w_te == 4'd0);
    // One step away from a terminal value: the step taken from here ends the count.
    assign w_pre_max  = (w_min == 4'(MAX_MINUTE)) && (w_st == 4'(MAX_SEC_TENS)) &&
                        (w_su == 4'(MAX_SEC_UNITS)) && (w_te == 4'(MAX_TENTH - 1));
    assign w_pre_zero = (w_min == 4'd0) && (w_st == 4'd0) && (w_su == 4'd0) && (w_te == 4'd1);

    always_comb begin
        w_state_nxt = r_state;
        w_div_nxt   = r_div;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        w_dig_load  = 1'b0;
        w_ld_min    = 4'd0;
        w_ld_st     = 4'd0;
        w_ld_su     = 4'd0;
        w_ld_te     = 4'd0;
        w_step_up   = 1'b0;
        w_step_dn   = 1'b0;
        w_run_step  = 1'b0;

        // Only the highest-priority asserted command is considered. If that
        // command is ignored in the current state, counting carries on as if
        // no command had arrived; a command that acts suppresses the step.
        if (i_clear) begin
            w_state_nxt = ST_IDLE;
            w_div_nxt   = '0;
            w_dig_load  = 1'b1;
        end else if (i_load) begin
            if (!w_running) begin
                if (!digits_in_range(i_load_minute, i_load_sec_tens,
                                     i_load_sec_units, i_load_tenth)) begin
                    w_err_nxt = 1'b1;
                end else begin
                    w_dig_load = 1'b1;
                    w_ld_min   = i_load_minute;
                    w_ld_st    = i_load_sec_tens;
                    w_ld_su    = i_load_sec_units;
                    w_ld_te    = i_load_tenth;
                    w_div_nxt  = '0;
                end
            end else begin
                w_run_step = 1'b1;
            end
        end else if (i_start_up || i_start_down) begin
            if (i_start_up && !i_start_down && (r_state != ST_UP) && !w_at_max) begin
                w_state_nxt = ST_UP;
                if (r_state == ST_IDLE) w_div_nxt = '0;
            end else if (i_start_down && !i_start_up && (r_state != ST_DOWN) && !w_at_zero) begin
                w_state_nxt = ST_DOWN;
                if (r_state == ST_IDLE) w_div_nxt = '0;
            end else begin
                w_run_step = 1'b1;
            end
        end else if (i_pause && w_running) begin
            w_state_nxt = ST_PAUSED;
        end else begin
            w_run_step = 1'b1;
        end

        if (w_run_step && w_running) begin
            if (r_div == DIV_LAST) begin
                w_div_nxt = '0;
                if (r_state == ST_UP) begin
                    w_step_up = 1'b1;
                    if (w_pre_max) begin
                        w_state_nxt = ST_IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end else begin
                    w_step_dn = 1'b1;
                    if (w_pre_zero) begin
                        w_state_nxt = ST_IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end
            end else begin
                w_div_nxt = r_div + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state    <= ST_IDLE;
            r_div      <= '0;
            r_done     <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_div      <= w_div_nxt;
            r_done     <= w_done_nxt;
            r_load_err <= w_err_nxt;
        end
    end

    // Digits chained tenth -> sec_units -> sec_tens -> minute via carry/borrow.
    stopwatch_digit #(.MAX(MAX_TENTH)) u_tenth (
        .i_clock(i_clock), .i_reset(i_reset), .i_inc(w_step_up), .i_dec(w_step_dn),
        .i_load(w_dig_load), .i_load_val(w_ld_te),
        .o_value(w_te), .o_carry(w_te_cy), .o_borrow(w_te_bw)
    );
    stopwatch_digit #(.MAX(MAX_SEC_UNITS)) u_sec_units (
        .i_clock(i_clock), .i_reset(i_reset), .i_inc(w_te_cy), .i_dec(w_te_bw),
        .i_load(w_dig_load), .i_load_val(w_ld_su),
        .o_value(w_su), .o_carry(w_su_cy), .o_borrow(w_su_bw)
    );
    stopwatch_digit #(.MAX(MAX_SEC_TENS)) u_sec_tens (
        .i_clock(i_clock), .i_reset(i_reset), .i_inc(w_su_cy), .i_dec(w_su_bw),
        .i_load(w_dig_load), .i_load_val(w_ld_st),
        .o_value(w_st), .o_carry(w_st_cy), .o_borrow(w_st_bw)
    );
    // Terminal detection stops the count before the minute could ever wrap,
    // so its carry/borrow are never needed.
    stopwatch_digit #(.MAX(MAX_MINUTE)) u_minute (
        .i_clock(i_clock), .i_reset(i_reset), .i_inc(w_st_cy), .i_dec(w_st_bw),
        .i_load(w_dig_load), .i_load_val(w_ld_min),
        .o_value(w_min), .o_carry(w_unused_min_cy), .o_borrow(w_unused_min_bw)
    );

    assign o_minute            = w_min;
    assign o_sec_tens          = w_st;
    assign o_sec_units         = w_su;
    assign o_tenth             = w_te;
    assign o_count_up_enable   = (r_state == ST_UP);
    assign o_count_down_enable = (r_state == ST_DOWN);
    assign o_done              = r_done;
    assign o_load_err          = r_load_err;

endmodule

// File: tb/tb_stopwatch_bcd_counter.sv
// Bench for stopwatch_bcd_counter: directed scenarios plus random command traffic,
// all cycles checked against a model that keeps time as a plain count of tenths.
// Outputs are sampled on the falling edge; inputs change only on the falling edge.
module tb_stopwatch_bcd_counter;

    localparam int TD     = 4;
    localparam int T_MAX  = 5999;   // 9:59.9 expressed in tenths
    localparam int S_IDLE = 0;
    localparam int S_UP   = 1;
    localparam int S_DN   = 2;
    localparam int S_PS   = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       s_up = 1'b0, s_dn = 1'b0, pse = 1'b0, clr = 1'b0, ld = 1'b0;
    logic [3:0] l_m = '0, l_st = '0, l_su = '0, l_t = '0;
    logic [3:0] minute, sec_tens, sec_units, tenth;
    logic       up_en, dn_en, done, load_err;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Reference model: elapsed time in tenths, divider phase, run state, pulses.
    int m_t = 0, m_div = 0, m_state = S_IDLE;
    bit m_done = 1'b0, m_err = 1'b0;

    stopwatch_bcd_counter #(.TICK_DIV(TD)) dut (
        .i_clock(clk), .i_reset(rst),
        .i_start_up(s_up), .i_start_down(s_dn), .i_pause(pse), .i_clear(clr), .i_load(ld),
        .i_load_minute(l_m), .i_load_sec_tens(l_st), .i_load_sec_units(l_su), .i_load_tenth(l_t),
        .o_minute(minute), .o_sec_tens(sec_tens), .o_sec_units(sec_units), .o_tenth(tenth),
        .o_count_up_enable(up_en), .o_count_down_enable(dn_en),
        .o_done(done), .o_load_err(load_err)
    );

    always #5 clk = ~clk;

    task automatic model_step();
        bit run;
        run    = 1'b0;
        m_done = 1'b0;
        m_err  = 1'b0;
        if (rst || clr) begin
            m_t = 0; m_div = 0; m_state = S_IDLE;
        end else if (ld) begin
            if (m_state == S_IDLE || m_state == S_PS) begin
                if (l_m > 9 || l_st > 5 || l_su > 9 || l_t > 9) m_err = 1'b1;
                else begin
                    m_t   = int'(l_m) * 600 + int'(l_st) * 100 + int'(l_su) * 10 + int'(l_t);
                    m_div = 0;
                end
            end else run = 1'b1;
        end else if (s_up || s_dn) begin
            if (s_up && !s_dn && m_state != S_UP && m_t != T_MAX) begin
                if (m_state == S_IDLE) m_div = 0;
                m_state = S_UP;
            end else if (s_dn && !s_up && m_state != S_DN && m_t != 0) begin
                if (m_state == S_IDLE) m_div = 0;
                m_state = S_DN;
            end else run = 1'b1;
        end else if (pse && (m_state == S_UP || m_state == S_DN)) begin
            m_state = S_PS;
        end else run = 1'b1;

        if (run && (m_state == S_UP || m_state == S_DN)) begin
            if (m_div == TD - 1) begin
                m_div = 0;
                m_t   = m_t + ((m_state == S_UP) ? 1 : -1);
                if ((m_state == S_UP && m_t == T_MAX) || (m_state == S_DN && m_t == 0)) begin
                    m_state = S_IDLE;
                    m_done  = 1'b1;
                end
            end else m_div = m_div + 1;
        end
    endtask

    function automatic logic [19:0] model_vec();
        return {4'(m_t / 600), 4'((m_t / 100) % 6), 4'((m_t / 10) % 10), 4'(m_t % 10),
                m_state == S_UP, m_state == S_DN, m_done, m_err};
    endfunction

    function automatic logic [19:0] dut_vec();
        return {minute, sec_tens, sec_units, tenth, up_en, dn_en, done, load_err};
    endfunction

    task automatic check_model();
        n_cmp++;
        if (dut_vec() !== model_vec()) begin
            n_bad++;
            $display("FAIL model cyc=%0d got {M,ST,SU,T,up,dn,done,err}=%05h want %05h",
                     cyc, dut_vec(), model_vec());
        end
    endtask

    task automatic lit(input string nm, input logic [19:0] got, input logic [19:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got %05h want %05h", nm, cyc, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        cyc++;
        check_model();
    endtask

    task automatic cmds_off();
        s_up = 1'b0; s_dn = 1'b0; pse = 1'b0; clr = 1'b0; ld = 1'b0;
    endtask

    task automatic do_load(input logic [3:0] m, input logic [3:0] st,
                           input logic [3:0] su, input logic [3:0] t);
        l_m = m; l_st = st; l_su = su; l_t = t; ld = 1'b1;
        tick();
        ld = 1'b0;
    endtask

    task automatic do_up();    s_up = 1'b1; tick(); s_up = 1'b0; endtask
    task automatic do_dn();    s_dn = 1'b1; tick(); s_dn = 1'b0; endtask
    task automatic do_pause(); pse  = 1'b1; tick(); pse  = 1'b0; endtask
    task automatic do_clear(); clr  = 1'b1; tick(); clr  = 1'b0; endtask

    function automatic logic [19:0] digits();
        return {4'h0, minute, sec_tens, sec_units, tenth};
    endfunction

    function automatic logic [19:0] flags();
        return {16'h0, up_en, dn_en, done, load_err};
    endfunction

    initial begin
        @(negedge clk);
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        lit("reset_state", dut_vec(), 20'h0);

        // Count up from 0:00.0: first step after TD cycles, 0:01.0 after 10 steps.
        do_load(0, 0, 0, 0);
        do_up();
        repeat (3) tick();
        lit("up_before_first_step", digits(), 20'h00000);
        tick();
        lit("up_first_step", digits(), 20'h00001);
        repeat (36) tick();
        lit("up_40_cycles", digits(), 20'h00010);
        lit("up_enables", flags(), 20'h00008);

        // Minute borrow with sec_tens wrapping to 5.
        do_clear();
        do_load(1, 0, 0, 0);
        do_dn();
        repeat (4) tick();
        lit("down_borrow", digits(), 20'h00599);
        lit("down_enables", flags(), 20'h00004);

        // Down to zero: done coincides with 0:00.0 and both enables low.
        do_clear();
        do_load(0, 0, 0, 2);
        do_dn();
        repeat (7) tick();
        lit("down_pre_zero", digits(), 20'h00001);
        tick();
        lit("down_zero_digits", digits(), 20'h00000);
        lit("down_zero_done", flags(), 20'h00002);
        tick();
        lit("down_done_one_cycle", flags(), 20'h00000);

        // Up to 9:59.9, then a start_up at the terminal value is rejected.
        do_load(9, 5, 9, 8);
        do_up();
        repeat (4) tick();
        lit("up_max_digits", digits(), 20'h09599);
        lit("up_max_done", flags(), 20'h00002);
        do_up();
        repeat (8) tick();
        lit("up_max_restart_rejected", dut_vec(), 20'h95990);

        // Pause after two divider cycles, hold, resume: step two cycles later.
        do_clear();
        do_up();
        repeat (2) tick();
        do_pause();
        repeat (20) tick();
        lit("paused_frozen", dut_vec(), 20'h00000);
        do_up();
        tick();
        lit("resume_no_step_yet", digits(), 20'h00000);
        tick();
        lit("resume_step", digits(), 20'h00001);

        // Rejected load keeps digits and pulses load_err once.
        do_clear();
        do_load(3, 2, 1, 4);
        do_load(0, 6, 0, 0);
        lit("load_err_pulse", dut_vec(), 20'h32141);
        tick();
        lit("load_err_cleared", dut_vec(), 20'h32140);

        // clear beats load in the same cycle.
        l_m = 5; l_st = 1; l_su = 1; l_t = 1; ld = 1'b1; clr = 1'b1;
        tick();
        cmds_off();
        lit("clear_over_load", dut_vec(), 20'h00000);

        // Reset in the middle of a count.
        do_up();
        repeat (9) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        lit("reset_mid_count", dut_vec(), 20'h00000);

        // Random command traffic, biased towards presets near the terminal values.
        for (int i = 0; i < 4000; i++) begin
            int r;
            int k;
            r = $urandom_range(0, 99);
            k = $urandom_range(0, 5);
            cmds_off();
            if (k == 0) begin
                l_m = 4'($urandom_range(0, 15)); l_st = 4'($urandom_range(0, 15));
                l_su = 4'($urandom_range(0, 15)); l_t = 4'($urandom_range(0, 15));
            end else if (k == 1) begin
                l_m = 9; l_st = 5; l_su = 9; l_t = 4'($urandom_range(4, 9));
            end else if (k == 2) begin
                l_m = 0; l_st = 0; l_su = 0; l_t = 4'($urandom_range(0, 6));
            end else if (k == 3) begin
                l_m = 1; l_st = 0; l_su = 0; l_t = 4'($urandom_range(0, 2));
            end else begin
                l_m = 4'($urandom_range(0, 9)); l_st = 4'($urandom_range(0, 5));
                l_su = 4'($urandom_range(0, 9)); l_t = 4'($urandom_range(0, 9));
            end
            if (r < 3)       s_up = 1'b1;
            else if (r < 6)  s_dn = 1'b1;
            else if (r < 8)  pse  = 1'b1;
            else if (r < 9)  clr  = 1'b1;
            else if (r < 13) ld   = 1'b1;
            else if (r == 13) rst = 1'b1;
            else if (r == 14) begin clr = 1'b1; ld = 1'b1; s_up = 1'b1; end
            else if (r == 15) begin s_up = 1'b1; s_dn = 1'b1; end
            tick();
            rst = 1'b0;
        end
        cmds_off();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
